// File: rtl/soc_timer_peripheral.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soc_timer_peripheral : memory-mapped prescaled 32-bit timer with compare/irq
// Revision: 1.0
// ---------------------------------------------------------------------------
module soc_timer_peripheral #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data,
  input  logic        we,
  output logic [31:0] data_out,
  output logic [31:0] unchanged_value,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic                   en_q, en_d;
  logic                   auto_q, auto_d;
  logic                   irq_en_q, irq_en_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            compare_q, compare_d;
  logic                   match_q, match_d;
  logic [31:0]            data_out_q;

  logic                   hit;
  logic [2:0]             off;
  logic                   wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic                   tick;
  logic                   cmp_eq;
  logic [31:0]            presc_ext;
  logic [31:0]            rdata;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^addr_in[1:0];

  assign hit        = (addr_in[31:5] == BASE_ADDR[31:5]);
  assign off        = addr_in[4:2];
  assign wr_ctrl    = we && hit && (off == OFF_CTRL);
  assign wr_presc   = we && hit && (off == OFF_PRESCALE);
  assign wr_count   = we && hit && (off == OFF_COUNT);
  assign wr_compare = we && hit && (off == OFF_COMPARE);
  assign wr_status  = we && hit && (off == OFF_STATUS);

  assign tick   = en_q && (presc_cnt_q == presc_q);
  assign cmp_eq = (count_q == compare_q);

  generate
    if (PRESC_WIDTH < 32) begin : g_presc_pad
      assign presc_ext = {{(32-PRESC_WIDTH){1'b0}}, presc_q};
    end else begin : g_presc_full
      assign presc_ext = presc_q;
    end
  endgenerate

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_CTRL:     rdata = {29'd0, irq_en_q, auto_q, en_q};
        OFF_PRESCALE: rdata = presc_ext;
        OFF_COUNT:    rdata = count_q;
        OFF_COMPARE:  rdata = compare_q;
        OFF_STATUS:   rdata = {31'd0, match_q};
        default:      rdata = 32'd0;
      endcase
    end
  end

  // STATUS reports 0 here so unmerged byte lanes write 0 and never clear flags.
  assign unchanged_value = (hit && (off == OFF_STATUS)) ? 32'd0 : rdata;

  // Ordering below encodes the priorities: W1C before tick (set wins),
  // tick before bus writes (COUNT/CTRL writes win).
  always_comb begin
    en_d        = en_q;
    auto_d      = auto_q;
    irq_en_d    = irq_en_q;
    presc_d     = presc_q;
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    compare_d   = compare_q;
    match_d     = match_q;

    if (wr_status && write_data[0]) begin
      match_d = 1'b0;
    end

    if (en_q) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_WIDTH'(1);
    end

    if (tick) begin
      if (cmp_eq) begin
        match_d = 1'b1;
        if (auto_q) begin
          count_d = 32'd0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl) begin
      en_d     = write_data[0];
      auto_d   = write_data[1];
      irq_en_d = write_data[2];
    end
    if (wr_presc) begin
      presc_d     = write_data[PRESC_WIDTH-1:0];
      presc_cnt_d = '0;
    end
    if (wr_count) begin
      count_d     = write_data;
      presc_cnt_d = '0;
    end
    if (wr_compare) begin
      compare_d = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      match_q     <= 1'b0;
      data_out_q  <= 32'd0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      match_q     <= match_d;
      data_out_q  <= rdata;
    end
  end

  assign data_out = data_out_q;
  assign irq      = match_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_timer_peripheral.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_soc_timer_peripheral : directed + randomized check against a rule model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_soc_timer_peripheral;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic        clk;
  logic        res_n;
  logic [31:0] addr_in;
  logic [31:0] write_data;
  logic        we;
  logic [31:0] data_out;
  logic [31:0] unchanged_value;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: architectural registers plus the prescaler count.
  logic        m_en, m_auto, m_ien, m_match;
  logic [31:0] m_presc, m_pcnt, m_count, m_cmp;

  soc_timer_peripheral #(
    .BASE_ADDR  (BASE),
    .PRESC_WIDTH(16)
  ) dut (
    .clk            (clk),
    .res_n          (res_n),
    .addr_in        (addr_in),
    .write_data     (write_data),
    .we             (we),
    .data_out       (data_out),
    .unchanged_value(unchanged_value),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0:    return {29'd0, m_ien, m_auto, m_en};
      3'd1:    return m_presc;
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_uv(input logic [31:0] a);
    if (a[31:5] == BASE[31:5] && a[4:2] == 3'd4) return 32'd0;
    return m_read(a);
  endfunction

  // One clock of the timer, applied from the behavioural rules.
  task automatic model_clock(input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic r);
    logic        hit, tick, eq;
    logic [2:0]  o;
    if (!r) begin
      m_en = 0; m_auto = 0; m_ien = 0; m_match = 0;
      m_presc = 0; m_pcnt = 0; m_count = 0; m_cmp = 0;
      return;
    end
    hit  = (a[31:5] == BASE[31:5]) && w;
    o    = a[4:2];
    tick = m_en && (m_pcnt == m_presc);
    eq   = (m_count == m_cmp);
    if (m_en) m_pcnt = tick ? 32'd0 : ((m_pcnt + 1) & PMASK);
    if (hit && o == 3'd4 && d[0] && !(tick && eq)) m_match = 0;
    if (tick) begin
      if (eq) begin
        m_match = 1;
        if (m_auto) m_count = 0;
        else        m_en = 0;
      end else begin
        m_count = m_count + 1;
      end
    end
    if (hit) begin
      case (o)
        3'd0: begin m_en = d[0]; m_auto = d[1]; m_ien = d[2]; end
        3'd1: begin m_presc = d & PMASK; m_pcnt = 0; end
        3'd2: begin m_count = d; m_pcnt = 0; end
        3'd3: m_cmp = d;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic r);
    logic [31:0] exp_do;
    addr_in = a; write_data = d; we = w; res_n = r;
    #1;
    check_eq("uval", unchanged_value, m_uv(a));
    exp_do = r ? m_read(a) : 32'd0;
    @(posedge clk); #1;
    model_clock(a, d, w, r);
    check_eq("rdata", data_out, exp_do);
    check_eq("irq", {31'd0, irq}, {31'd0, m_match & m_ien});
  endtask

  task automatic wr(input int o, input logic [31:0] d);
    step(BASE + 32'(o * 4), d, 1'b1, 1'b1);
  endtask

  task automatic rd(input int o);
    step(BASE + 32'(o * 4), 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w, r;
    int          o, sel;

    res_n = 1'b0; addr_in = 32'd0; write_data = 32'd0; we = 1'b0;
    m_en = 0; m_auto = 0; m_ien = 0; m_match = 0;
    m_presc = 0; m_pcnt = 0; m_count = 0; m_cmp = 0;
    @(posedge clk); #1;

    // Reset with a concurrent COUNT write
    step(BASE + 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(BASE + 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0);
    rd(2); check_eq("rst_count", data_out, 32'd0);
    rd(0); check_eq("rst_ctrl", data_out, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);

    // Readback and unmapped offset
    wr(2, 32'h1234_5678);
    rd(2); check_eq("rb_count", data_out, 32'h1234_5678);
    rd(5); check_eq("rb_unmapped", data_out, 32'd0);

    // One-shot
    wr(1, 2); wr(3, 3); wr(2, 0); wr(0, 32'b101);
    repeat (12) rd(4);
    check_eq("os_irq", {31'd0, irq}, 32'd1);
    rd(2); check_eq("os_count", data_out, 32'd3);
    rd(0); check_eq("os_ctrl", data_out, 32'b100);
    wr(4, 1);
    check_eq("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload
    wr(0, 0); wr(4, 1); wr(1, 0); wr(3, 1); wr(2, 0); wr(0, 32'b011);
    for (int k = 0; k < 6; k++) begin
      rd(2); check_eq("ar_seq", data_out, 32'(k % 2));
    end
    rd(4); check_eq("ar_match", data_out, 32'd1);
    check_eq("ar_irq", {31'd0, irq}, 32'd0);

    // Wrap and write/tick collision
    wr(0, 0); wr(4, 1); wr(1, 0); wr(3, 5); wr(2, 32'hFFFF_FFFF); wr(0, 1);
    rd(2); check_eq("wrap_pre", data_out, 32'hFFFF_FFFF);
    rd(2); check_eq("wrap_zero", data_out, 32'd0);
    rd(4); check_eq("wrap_match", data_out, 32'd0);
    wr(2, 32'hA);
    rd(2); check_eq("coll_count", data_out, 32'hA);
    wr(0, 0);

    // W1C vs set race, then a byte-masked STATUS write
    wr(4, 1); wr(1, 0); wr(3, 7); wr(2, 7); wr(0, 1);
    wr(4, 1);
    rd(4); check_eq("race_match", data_out, 32'd1);
    wr(4, 0);
    rd(4); check_eq("merge_match", data_out, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 99);
      o   = $urandom_range(0, 7);
      a   = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
      if (sel < 5)      a = $urandom;
      else if (sel < 8) a = BASE + 32'h20 + 32'(o * 4);
      r = ($urandom_range(0, 149) != 0);
      w = ($urandom_range(0, 99) < 35);
      case (o)
        0: d = ($urandom & 32'hFFFF_FFF6) | 32'($urandom_range(0, 3) != 0) | 32'($urandom_range(0, 1) << 2);
        1: d = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 3));
        2: begin
          case ($urandom_range(0, 2))
            0:       d = 32'($urandom_range(0, 8));
            1:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: d = $urandom;
          endcase
        end
        3: d = 32'($urandom_range(0, 8));
        default: d = $urandom;
      endcase
      step(a, d, w, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
